// File: rtl/sdram_fifo_pkg.sv
// Shared constants, FSM encoding and address-advance helper for the SDRAM FIFO front-end.
package sdram_fifo_pkg;

  localparam int DEPTH     = 1024;
  localparam int DW        = 16;
  localparam int AW        = 24;
  localparam int MAX_BURST = 512;
  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int BLW       = $clog2(MAX_BURST) + 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_BUSY,
    RD_REQ,
    RD_BUSY
  } state_t;

  // Sums are kept at AW+1 bits so a region near the top of memory wraps to begin instead of overflowing.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0]  cur,
                                              input logic [BLW-1:0] len,
                                              input logic [AW-1:0]  b_addr,
                                              input logic [AW-1:0]  e_addr);
    logic [AW:0] len_x;
    logic [AW:0] sum;
    len_x = {{(AW + 1 - BLW){1'b0}}, len};
    sum   = {1'b0, cur} + len_x;
    if ((sum + len_x) > {1'b0, e_addr}) begin
      next_addr = b_addr;
    end else begin
      next_addr = sum[AW-1:0];
    end
  endfunction

endpackage

// File: rtl/sdram_fifo_ctrl_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush; head reads as zero while empty.
module sync_fifo #(
  parameter int DEPTH = 1024,
  parameter int DW    = 16,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [PW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop) begin
        count <= count + (PW + 1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (PW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sdram_fifo_ctrl.sv
// SDRAM front-end: buffers write/read streams and schedules one burst at a time,
// walking each address circularly through its programmable region.
module sdram_fifo_ctrl
  import sdram_fifo_pkg::*;
(
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           init_end,
  input  logic           wr_fifo_wr_en,
  input  logic [DW-1:0]  wr_fifo_wr_data,
  output logic           wr_fifo_full,
  input  logic [AW-1:0]  wr_b_addr,
  input  logic [AW-1:0]  wr_e_addr,
  input  logic [BLW-1:0] wr_burst_len,
  input  logic           wr_rst,
  input  logic           rd_fifo_rd_en,
  output logic [DW-1:0]  rd_fifo_rd_data,
  output logic [CW-1:0]  rd_fifo_num,
  input  logic [AW-1:0]  rd_b_addr,
  input  logic [AW-1:0]  rd_e_addr,
  input  logic [BLW-1:0] rd_burst_len,
  input  logic           rd_rst,
  input  logic           read_valid,
  output logic           sdram_wr_req,
  output logic [AW-1:0]  sdram_wr_addr,
  input  logic           sdram_wr_ack,
  output logic [DW-1:0]  sdram_data_in,
  output logic           sdram_rd_req,
  output logic [AW-1:0]  sdram_rd_addr,
  input  logic           sdram_rd_ack,
  input  logic [DW-1:0]  sdram_rd_data
);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] rd_space;
  logic          wr_empty;
  logic          rd_full;
  logic          rd_empty;
  logic          wr_ack_d;
  logic          rd_ack_d;
  logic          wr_rst_pend;
  logic          rd_rst_pend;
  logic          wr_path_busy;
  logic          rd_path_busy;
  logic          wr_done;
  logic          rd_done;
  logic          wr_flush;
  logic          rd_flush;
  logic          wr_eligible;
  logic          rd_eligible;

  sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_wr_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .flush (wr_flush),
    .push  (wr_fifo_wr_en),
    .din   (wr_fifo_wr_data),
    .pop   (sdram_wr_ack && !wr_empty),
    .head  (sdram_data_in),
    .count (wr_count),
    .full  (wr_fifo_full),
    .empty (wr_empty)
  );

  sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rd_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .flush (rd_flush),
    .push  (sdram_rd_ack),
    .din   (sdram_rd_data),
    .pop   (rd_fifo_rd_en && !rd_empty),
    .head  (rd_fifo_rd_data),
    .count (rd_fifo_num),
    .full  (rd_full),
    .empty (rd_empty)
  );

  assign wr_path_busy = (state == WR_REQ) || (state == WR_BUSY);
  assign rd_path_busy = (state == RD_REQ) || (state == RD_BUSY);
  assign wr_done      = (state == WR_BUSY) && wr_ack_d && !sdram_wr_ack;
  assign rd_done      = (state == RD_BUSY) && rd_ack_d && !sdram_rd_ack;

  // A flush requested mid-burst is deferred until the ack falling edge ends that burst.
  assign wr_flush = wr_done ? (wr_rst_pend || wr_rst) : (wr_rst && !wr_path_busy);
  assign rd_flush = rd_done ? (rd_rst_pend || rd_rst) : (rd_rst && !rd_path_busy);

  assign rd_space    = CW'(DEPTH) - rd_fifo_num;
  assign wr_eligible = !wr_rst && !wr_empty && (wr_count >= {1'b0, wr_burst_len});
  assign rd_eligible = read_valid && !rd_rst && !rd_full && (rd_space >= {1'b0, rd_burst_len});

  assign sdram_wr_req = (state == WR_REQ);
  assign sdram_rd_req = (state == RD_REQ);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (init_end) begin
          if (wr_eligible) begin
            state_nxt = WR_REQ;
          end else if (rd_eligible) begin
            state_nxt = RD_REQ;
          end
        end
      end
      WR_REQ:  if (sdram_wr_ack) state_nxt = WR_BUSY;
      WR_BUSY: if (wr_done)      state_nxt = IDLE;
      RD_REQ:  if (sdram_rd_ack) state_nxt = RD_BUSY;
      RD_BUSY: if (rd_done)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sdram_wr_addr <= wr_b_addr;
      sdram_rd_addr <= rd_b_addr;
      wr_ack_d      <= 1'b0;
      rd_ack_d      <= 1'b0;
      wr_rst_pend   <= 1'b0;
      rd_rst_pend   <= 1'b0;
    end else begin
      wr_ack_d <= sdram_wr_ack;
      rd_ack_d <= sdram_rd_ack;

      if (wr_flush) begin
        sdram_wr_addr <= wr_b_addr;
      end else if (wr_done) begin
        sdram_wr_addr <= next_addr(sdram_wr_addr, wr_burst_len, wr_b_addr, wr_e_addr);
      end

      if (rd_flush) begin
        sdram_rd_addr <= rd_b_addr;
      end else if (rd_done) begin
        sdram_rd_addr <= next_addr(sdram_rd_addr, rd_burst_len, rd_b_addr, rd_e_addr);
      end

      if (wr_done) begin
        wr_rst_pend <= 1'b0;
      end else if (wr_rst && wr_path_busy) begin
        wr_rst_pend <= 1'b1;
      end

      if (rd_done) begin
        rd_rst_pend <= 1'b0;
      end else if (rd_rst && rd_path_busy) begin
        rd_rst_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Randomized bench for sdram_fifo_ctrl acting as the SDRAM controller, checked against a
// queue-based model of both FIFOs and the circular region address walk.
module tb_sdram_fifo_ctrl;
  import sdram_fifo_pkg::*;

  logic           sys_clk = 1'b0;
  logic           sys_rst_n;
  logic           init_end;
  logic           wr_fifo_wr_en;
  logic [DW-1:0]  wr_fifo_wr_data;
  logic           wr_fifo_full;
  logic [AW-1:0]  wr_b_addr;
  logic [AW-1:0]  wr_e_addr;
  logic [BLW-1:0] wr_burst_len;
  logic           wr_rst;
  logic           rd_fifo_rd_en;
  logic [DW-1:0]  rd_fifo_rd_data;
  logic [CW-1:0]  rd_fifo_num;
  logic [AW-1:0]  rd_b_addr;
  logic [AW-1:0]  rd_e_addr;
  logic [BLW-1:0] rd_burst_len;
  logic           rd_rst;
  logic           read_valid;
  logic           sdram_wr_req;
  logic [AW-1:0]  sdram_wr_addr;
  logic           sdram_wr_ack;
  logic [DW-1:0]  sdram_data_in;
  logic           sdram_rd_req;
  logic [AW-1:0]  sdram_rd_addr;
  logic           sdram_rd_ack;
  logic [DW-1:0]  sdram_rd_data;

  int checks = 0;
  int passed = 0;

  logic [DW-1:0] wq[$];
  logic [DW-1:0] rq[$];
  longint        mWrAddr;
  longint        mRdAddr;
  bit            mWrFlush;
  bit            mRdFlush;

  sdram_fifo_ctrl dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .init_end        (init_end),
    .wr_fifo_wr_en   (wr_fifo_wr_en),
    .wr_fifo_wr_data (wr_fifo_wr_data),
    .wr_fifo_full    (wr_fifo_full),
    .wr_b_addr       (wr_b_addr),
    .wr_e_addr       (wr_e_addr),
    .wr_burst_len    (wr_burst_len),
    .wr_rst          (wr_rst),
    .rd_fifo_rd_en   (rd_fifo_rd_en),
    .rd_fifo_rd_data (rd_fifo_rd_data),
    .rd_fifo_num     (rd_fifo_num),
    .rd_b_addr       (rd_b_addr),
    .rd_e_addr       (rd_e_addr),
    .rd_burst_len    (rd_burst_len),
    .rd_rst          (rd_rst),
    .read_valid      (read_valid),
    .sdram_wr_req    (sdram_wr_req),
    .sdram_wr_addr   (sdram_wr_addr),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_data_in   (sdram_data_in),
    .sdram_rd_req    (sdram_rd_req),
    .sdram_rd_addr   (sdram_rd_addr),
    .sdram_rd_ack    (sdram_rd_ack),
    .sdram_rd_data   (sdram_rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] wHead();
    return (wq.size() > 0) ? 32'(wq[0]) : 32'h0;
  endfunction

  function automatic logic [31:0] rHead();
    return (rq.size() > 0) ? 32'(rq[0]) : 32'h0;
  endfunction

  // Model the effect of the inputs currently driven, then advance one clock.
  task automatic applyStimulus();
    bit wpop, wpush, rpop, rpush;
    if (!sys_rst_n) begin
      wq.delete();
      rq.delete();
      mWrAddr = wr_b_addr;
      mRdAddr = rd_b_addr;
    end else begin
      wpop  = sdram_wr_ack && (wq.size() > 0);
      wpush = wr_fifo_wr_en && (wq.size() < DEPTH);
      rpop  = rd_fifo_rd_en && (rq.size() > 0);
      rpush = sdram_rd_ack && (rq.size() < DEPTH);
      if (wpop)  void'(wq.pop_front());
      if (wpush) wq.push_back(wr_fifo_wr_data);
      if (rpop)  void'(rq.pop_front());
      if (rpush) rq.push_back(sdram_rd_data);
      if (mWrFlush) wq.delete();
      if (mRdFlush) rq.delete();
    end
    mWrFlush = 0;
    mRdFlush = 0;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pushWords(input int n, input bit seq);
    for (int i = 0; i < n; i++) begin
      wr_fifo_wr_en   = 1'b1;
      wr_fifo_wr_data = seq ? 16'(i) : 16'($urandom);
      applyStimulus();
    end
    wr_fifo_wr_en = 1'b0;
  endtask

  task automatic runWriteBurst(input int len, input int rstBeat);
    int     waited = 0;
    longint nxt;
    while (sdram_wr_req !== 1'b1 && waited < 100) begin
      applyStimulus();
      waited++;
    end
    checkOutput("wr_req_raised", 32'(sdram_wr_req), 32'd1);
    if (sdram_wr_req !== 1'b1) return;
    checkOutput("wr_addr_start", 32'(sdram_wr_addr), 32'(mWrAddr));
    for (int i = 0; i < len; i++) begin
      sdram_wr_ack = 1'b1;
      wr_rst       = (i == rstBeat);
      checkOutput("wr_beat_data", 32'(sdram_data_in), wHead());
      checkOutput("rd_req_quiet", 32'(sdram_rd_req), 32'd0);
      applyStimulus();
      if (i == 0) checkOutput("wr_req_drop", 32'(sdram_wr_req), 32'd0);
    end
    wr_rst       = 1'b0;
    sdram_wr_ack = 1'b0;
    if (rstBeat >= 0) mWrFlush = 1;
    applyStimulus();
    if (rstBeat >= 0) begin
      mWrAddr = wr_b_addr;
    end else begin
      nxt     = mWrAddr + len;
      mWrAddr = ((nxt + len) > longint'(wr_e_addr)) ? longint'(wr_b_addr) : nxt;
    end
    checkOutput("wr_addr_next", 32'(sdram_wr_addr), 32'(mWrAddr));
  endtask

  task automatic runReadBurst(input int len, input bit seq, input logic [15:0] base);
    int     waited = 0;
    longint nxt;
    while (sdram_rd_req !== 1'b1 && waited < 100) begin
      applyStimulus();
      waited++;
    end
    checkOutput("rd_req_raised", 32'(sdram_rd_req), 32'd1);
    read_valid = 1'b0;
    if (sdram_rd_req !== 1'b1) return;
    checkOutput("rd_addr_start", 32'(sdram_rd_addr), 32'(mRdAddr));
    for (int i = 0; i < len; i++) begin
      sdram_rd_ack  = 1'b1;
      sdram_rd_data = seq ? base + 16'(i) : 16'($urandom);
      applyStimulus();
      if (i == 0) checkOutput("rd_req_drop", 32'(sdram_rd_req), 32'd0);
    end
    sdram_rd_ack  = 1'b0;
    sdram_rd_data = '0;
    applyStimulus();
    nxt     = mRdAddr + len;
    mRdAddr = ((nxt + len) > longint'(rd_e_addr)) ? longint'(rd_b_addr) : nxt;
    checkOutput("rd_addr_next", 32'(sdram_rd_addr), 32'(mRdAddr));
    checkOutput("rd_num_burst", 32'(rd_fifo_num), 32'(rq.size()));
  endtask

  task automatic popReads(input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput("rd_head", 32'(rd_fifo_rd_data), rHead());
      checkOutput("rd_num", 32'(rd_fifo_num), 32'(rq.size()));
      rd_fifo_rd_en = 1'b1;
      applyStimulus();
    end
    rd_fifo_rd_en = 1'b0;
    checkOutput("rd_num_drained", 32'(rd_fifo_num), 32'(rq.size()));
  endtask

  initial begin
    int wl;
    int rl;
    sys_rst_n       = 1'b0;
    init_end        = 1'b0;
    wr_fifo_wr_en   = 1'b0;
    wr_fifo_wr_data = '0;
    wr_b_addr       = 24'd0;
    wr_e_addr       = 24'd30;
    wr_burst_len    = 10'd10;
    wr_rst          = 1'b0;
    rd_fifo_rd_en   = 1'b0;
    rd_b_addr       = 24'h001000;
    rd_e_addr       = 24'h001014;
    rd_burst_len    = 10'd8;
    rd_rst          = 1'b0;
    read_valid      = 1'b0;
    sdram_wr_ack    = 1'b0;
    sdram_rd_ack    = 1'b0;
    sdram_rd_data   = '0;
    mWrFlush        = 0;
    mRdFlush        = 0;

    applyStimulus();
    applyStimulus();
    checkOutput("rst_rd_num", 32'(rd_fifo_num), 32'd0);
    checkOutput("rst_wr_full", 32'(wr_fifo_full), 32'd0);
    checkOutput("rst_wr_req", 32'(sdram_wr_req), 32'd0);
    checkOutput("rst_rd_req", 32'(sdram_rd_req), 32'd0);
    checkOutput("rst_wr_addr", 32'(sdram_wr_addr), 32'(mWrAddr));
    checkOutput("rst_rd_addr", 32'(sdram_rd_addr), 32'(mRdAddr));
    checkOutput("rst_rd_head", 32'(rd_fifo_rd_data), 32'h0);
    checkOutput("rst_wr_head", 32'(sdram_data_in), 32'h0);
    sys_rst_n = 1'b1;

    // Read prefetch is eligible but init_end holds it off.
    read_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("init_holdoff", 32'(sdram_rd_req), 32'd0);
    end
    read_valid = 1'b0;
    init_end   = 1'b1;
    applyStimulus();

    // First burst: request rises one cycle after the tenth push.
    pushWords(10, 1'b1);
    checkOutput("wr_req_latency0", 32'(sdram_wr_req), 32'd0);
    applyStimulus();
    checkOutput("wr_req_latency1", 32'(sdram_wr_req), 32'd1);
    runWriteBurst(10, -1);
    pushWords(10, 1'b0);
    runWriteBurst(10, -1);
    pushWords(10, 1'b0);
    runWriteBurst(10, -1);
    checkOutput("wr_wrap", 32'(sdram_wr_addr), 32'd0);

    // Write and read become eligible in the same cycle.
    init_end = 1'b0;
    pushWords(10, 1'b0);
    read_valid = 1'b1;
    applyStimulus();
    checkOutput("both_hold_wr", 32'(sdram_wr_req), 32'd0);
    init_end = 1'b1;
    applyStimulus();
    checkOutput("prio_wr_req", 32'(sdram_wr_req), 32'd1);
    checkOutput("prio_rd_req", 32'(sdram_rd_req), 32'd0);
    runWriteBurst(10, -1);
    runReadBurst(8, 1'b1, 16'h00A0);
    popReads(8);
    rd_fifo_rd_en = 1'b1;
    applyStimulus();
    rd_fifo_rd_en = 1'b0;
    checkOutput("pop_empty_num", 32'(rd_fifo_num), 32'd0);
    checkOutput("pop_empty_head", 32'(rd_fifo_rd_data), 32'h0);

    // Idle write flush takes effect at once.
    pushWords(3, 1'b0);
    wr_rst   = 1'b1;
    mWrFlush = 1;
    applyStimulus();
    wr_rst  = 1'b0;
    mWrAddr = wr_b_addr;
    checkOutput("wr_rst_idle_head", 32'(sdram_data_in), wHead());
    checkOutput("wr_rst_idle_addr", 32'(sdram_wr_addr), 32'(mWrAddr));

    // Flush during a burst is deferred to the ack falling edge.
    init_end = 1'b0;
    pushWords(15, 1'b0);
    init_end = 1'b1;
    runWriteBurst(10, 4);
    checkOutput("wr_rst_busy_head", 32'(sdram_data_in), wHead());
    applyStimulus();
    applyStimulus();
    checkOutput("wr_rst_busy_noreq", 32'(sdram_wr_req), 32'd0);

    // Fill the write FIFO; the 1025th word must be dropped.
    init_end     = 1'b0;
    wr_burst_len = 10'd512;
    pushWords(1023, 1'b0);
    checkOutput("wr_full_1023", 32'(wr_fifo_full), 32'd0);
    pushWords(1, 1'b0);
    checkOutput("wr_full_1024", 32'(wr_fifo_full), 32'd1);
    pushWords(1, 1'b0);
    checkOutput("wr_full_1025", 32'(wr_fifo_full), 32'd1);
    init_end = 1'b1;
    runWriteBurst(512, -1);
    runWriteBurst(512, -1);
    checkOutput("wr_full_drained", 32'(wr_fifo_full), 32'd0);
    checkOutput("wr_dropped_head", 32'(sdram_data_in), wHead());

    // Move the read region to the top of memory and re-anchor with an idle flush.
    rd_b_addr = 24'hFFFF00;
    rd_e_addr = 24'hFFFFFF;
    rd_rst    = 1'b1;
    mRdFlush  = 1;
    applyStimulus();
    rd_rst  = 1'b0;
    mRdAddr = rd_b_addr;
    checkOutput("rd_rst_idle_addr", 32'(sdram_rd_addr), 32'(mRdAddr));

    for (int r = 0; r < 8; r++) begin
      wl           = int'($urandom_range(1, 16));
      wr_burst_len = 10'(wl);
      pushWords(wl, 1'b0);
      runWriteBurst(wl, -1);
      rl           = int'($urandom_range(1, 64));
      rd_burst_len = 10'(rl);
      read_valid   = 1'b1;
      runReadBurst(rl, 1'b0, 16'h0);
      popReads(rl);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sdram_fifo_ctrl.md
Name: sdram_fifo_ctrl

Overview:
- Front-end of the SDRAM controller. Buffers the user write stream into a write FIFO and the SDRAM read stream into a read FIFO.
- Issues burst write/read requests (request, 24-bit address, burst length) to the SDRAM controller.
- Advances write and read addresses circularly between programmable begin/end addresses.
- Single clock domain; sits directly upstream of the SDRAM controller.

Parameters:
- DEPTH, 1024, entries in each internal FIFO (power of two, must be ≥ max burst length 512).
- DW, 16, data width.
- AW, 24, SDRAM linear address width ({bank, row, col}).

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst_n  in  1  reset; synchronous, active-low.
- init_end  in  1  SDRAM initialisation done; no request is raised before it is high.
- wr_fifo_wr_en  in  1  push user write data.
- wr_fifo_wr_data  in  16  user write data.
- wr_fifo_full  out  1  write FIFO full.
- wr_b_addr  in  24  write region begin address.
- wr_e_addr  in  24  write region end address (exclusive).
- wr_burst_len  in  10  write burst length, 1..512.
- wr_rst  in  1  flush write FIFO; write address returns to wr_b_addr.
- rd_fifo_rd_en  in  1  pop user read data.
- rd_fifo_rd_data  out  16  read FIFO head (first-word-fall-through).
- rd_fifo_num  out  11  read FIFO occupancy.
- rd_b_addr  in  24  read region begin address.
- rd_e_addr  in  24  read region end address (exclusive).
- rd_burst_len  in  10  read burst length, 1..512.
- rd_rst  in  1  flush read FIFO; read address returns to rd_b_addr.
- read_valid  in  1  enables read prefetch.
- sdram_wr_req  out  1  burst write request.
- sdram_wr_addr  out  24  burst write start address.
- sdram_wr_ack  in  1  high for each accepted write beat.
- sdram_data_in  out  16  write FIFO head, driven to the controller.
- sdram_rd_req  out  1  burst read request.
- sdram_rd_addr  out  24  burst read start address.
- sdram_rd_ack  in  1  high for each valid read beat.
- sdram_rd_data  in  16  read beat data.

Behaviour:
- Reset (sys_rst_n=0 at a clock edge):
  - Both FIFOs empty; rd_fifo_num=0; wr_fifo_full=0.
  - sdram_wr_req=0, sdram_rd_req=0.
  - sdram_wr_addr=wr_b_addr; sdram_rd_addr=rd_b_addr.
  - State=IDLE.
  - FIFO heads read as 0 while empty.
- FIFOs:
  - Synchronous, first-word-fall-through; a pop exposes the next word on the next cycle.
  - A push when full is dropped. A pop when empty is ignored, and the count stays 0.
  - Simultaneous push and pop when neither full nor empty leaves the count unchanged.
- Write FIFO traffic:
  - Push: wr_fifo_wr_en.
  - Pop: every cycle sdram_wr_ack=1; sdram_data_in is the head combinationally.
- Read FIFO traffic:
  - Push: every cycle sdram_rd_ack=1 (data sdram_rd_data).
  - Pop: rd_fifo_rd_en.
- FSM states: IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY.
- IDLE, evaluated each cycle with init_end=1:
  - Write eligible: write count ≥ wr_burst_len.
  - Read eligible: read_valid=1 and (DEPTH − read count) ≥ rd_burst_len.
  - Write has priority when both are eligible in the same cycle.
  - Next cycle: state WR_REQ or RD_REQ, and the matching req goes to 1 (registered, 1-cycle latency).
- WR_REQ: sdram_wr_req stays 1 until the first cycle sdram_wr_ack=1. Then req=0 next cycle and state=WR_BUSY.
- WR_BUSY: waits for the falling edge of sdram_wr_ack (ack_d=1, ack=0). On that cycle:
  - sdram_wr_addr += wr_burst_len.
  - If the new value + wr_burst_len > wr_e_addr, sdram_wr_addr = wr_b_addr instead.
  - State returns to IDLE.
- RD_REQ / RD_BUSY: identical to the write pair, using the rd_* signals.
- Requests are never re-raised while BUSY. At most one burst is outstanding.
- Addresses are 24-bit unsigned. The sum is computed at 25 bits before the compare, so there is no silent wrap.
- wr_rst / rd_rst:
  - When the affected path is not in REQ/BUSY: applied in the same cycle (flush FIFO, address = begin).
  - Otherwise: latched as pending and applied on the ack falling edge, replacing the address increment.
  - During a pending write flush, write pops still occur.
- Reset mid-burst: all state is cleared immediately. The controller itself is reset by the same sys_rst_n.
- init_end=0: requests are held off; FIFO pushes are still accepted.

Decomposition:
- Package sdram_fifo_pkg:
  - FSM state encoding.
  - DEPTH, DW, AW constants.
  - MAX_BURST=512.
- Sub-module sync_fifo (DEPTH, DW), instanced twice. It provides push, pop, head, count, full and empty.

Test Plan:
- Reset then init_end=1, wr_burst_len=10, push 10 words 0x0000..0x0009 → sdram_wr_req rises 1 cycle after the 10th push. The bench drives 10 ack cycles; sdram_data_in=0..9 in order; sdram_wr_addr goes 0→10 after ack falls.
- wr_b_addr=0, wr_e_addr=30, burst 10, three bursts → addresses 0, 10, 20, then 0 (wrap).
- Write and read both eligible in the same IDLE cycle → sdram_wr_req first. sdram_rd_req is raised only after the write ack falls.
- read_valid=1, rd_burst_len=8, bench returns 8 beats 0xA0..0xA7 → rd_fifo_num=8. rd_fifo_rd_data=0xA0 first, and each pop exposes the next value.
- wr_rst pulsed during WR_BUSY → burst completes, write FIFO flushes at ack fall, sdram_wr_addr=wr_b_addr.
- Push 1025 words with no acks → wr_fifo_full=1 after 1024; the 1025th word is dropped (count stays 1024).
